// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Fetches 16-bit instructions from an external memory, optionally fetches
//   an immediate word, presents decoded operands to an external ALU and
//   writes the ALU result back into an internal register file.
//
//   Instruction: [15] useAU, [14:11] OpcodeB, [10:9] Mode, [8:6] Rd,
//                [5:3] Rn, [2:0] Rm.  Mode 2'b01 carries an immediate word.
//                16'hFFFF fetched as an instruction halts until reset.
//
//   Ports
//     clk, rst_n        clock, synchronous active-low reset
//     start             leave IDLE and begin fetching
//     instr_req/addr    fetch request and word address (pc)
//     instr_valid/data  fetch completion and fetched word
//     OpcodeB, Immediate, Mode, useAU, Rn_data, Rm_data
//                       registered ALU controls/operands, held until next DECODE
//     Rd_data           ALU result, written to regs[Rd] at the end of EXEC
//     busy, halted      status (busy is low only in IDLE and HALT)
module alu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned NREG     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        instr_req,
  output logic [15:0] instr_addr,
  input  logic        instr_valid,
  input  logic [15:0] instr_data,
  output logic [3:0]  OpcodeB,
  output logic [15:0] Immediate,
  output logic [1:0]  Mode,
  output logic        useAU,
  output logic [15:0] Rn_data,
  output logic [15:0] Rm_data,
  input  logic [15:0] Rd_data,
  output logic        busy,
  output logic        halted
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    FETCH_IMM,
    DECODE,
    EXEC,
    HALT
  } state_t;

  localparam logic [15:0] HALT_WORD = 16'hFFFF;
  localparam logic [1:0]  MODE_IMM  = 2'b01;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [15:0] imm;
  logic [15:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      imm       <= '0;
      OpcodeB   <= '0;
      Immediate <= '0;
      Mode      <= '0;
      useAU     <= 1'b0;
      Rn_data   <= '0;
      Rm_data   <= '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= FETCH;
        end

        FETCH: begin
          if (instr_valid) begin
            pc <= pc + 16'd1;
            ir <= instr_data;
            if (instr_data == HALT_WORD) begin
              state <= HALT;
            end else if (instr_data[10:9] == MODE_IMM) begin
              state <= FETCH_IMM;
            end else begin
              // Instructions without an immediate present a zero immediate.
              imm   <= '0;
              state <= DECODE;
            end
          end
        end

        FETCH_IMM: begin
          if (instr_valid) begin
            pc    <= pc + 16'd1;
            imm   <= instr_data;
            state <= DECODE;
          end
        end

        DECODE: begin
          // Register reads happen after the previous EXEC write has landed,
          // so a dependent instruction always sees the fresh value.
          useAU     <= ir[15];
          OpcodeB   <= ir[14:11];
          Mode      <= ir[10:9];
          Immediate <= imm;
          Rn_data   <= regs[ir[5:3]];
          Rm_data   <= regs[ir[2:0]];
          state     <= EXEC;
        end

        EXEC: begin
          regs[ir[8:6]] <= Rd_data;
          state         <= FETCH;
        end

        HALT: begin
          state <= HALT;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Status and fetch outputs decode directly from the state register.
  assign instr_req  = (state == FETCH) || (state == FETCH_IMM);
  assign instr_addr = pc;
  assign busy       = (state != IDLE) && (state != HALT);
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Primary DUT (RESET_PC = 0)
  logic        rst_n, start, instr_req, instr_valid, useAU, busy, halted;
  logic [15:0] instr_addr, instr_data, Immediate, Rn_data, Rm_data, Rd_data;
  logic [3:0]  OpcodeB;
  logic [1:0]  Mode;

  alu_sequencer #(.RESET_PC(16'h0000), .NREG(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr_data(instr_data),
    .OpcodeB(OpcodeB), .Immediate(Immediate), .Mode(Mode), .useAU(useAU),
    .Rn_data(Rn_data), .Rm_data(Rm_data), .Rd_data(Rd_data),
    .busy(busy), .halted(halted)
  );

  // Second DUT for the wrapping reset address
  logic        rst2_n, start2, instr_req2, useAU2, busy2, halted2;
  logic        instr_valid2;
  logic [15:0] instr_addr2, instr_data2, Immediate2, Rn_data2, Rm_data2, Rd_data2;
  logic [3:0]  OpcodeB2;
  logic [1:0]  Mode2;

  alu_sequencer #(.RESET_PC(16'hFFFF), .NREG(8)) dut2 (
    .clk(clk), .rst_n(rst2_n), .start(start2),
    .instr_req(instr_req2), .instr_addr(instr_addr2),
    .instr_valid(instr_valid2), .instr_data(instr_data2),
    .OpcodeB(OpcodeB2), .Immediate(Immediate2), .Mode(Mode2), .useAU(useAU2),
    .Rn_data(Rn_data2), .Rm_data(Rm_data2), .Rd_data(Rd_data2),
    .busy(busy2), .halted(halted2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        au;
    logic [3:0]  op;
    logic [1:0]  mode;
    logic [15:0] imm;
    logic [15:0] rn;
    logic [15:0] rm;
    logic [15:0] res;
  } alu_rec_t;

  // External ALU behaviour used to produce Rd_data.
  function automatic logic [15:0] alu_fn(input alu_rec_t r);
    logic [15:0] b;
    b = (r.mode == 2'b01) ? r.imm : r.rm;
    if (r.au) return r.op[0] ? r.rn + b : r.rn - b;
    else      return r.op[0] ? r.rn ^ b : r.rn | b;
  endfunction

  logic [15:0] mem [65536];
  logic [15:0] m_regs [8];
  logic [15:0] m_pc, m_word, stall_addr;
  int          stall_left = 0;
  bit          m_running, m_halt, m_in_imm, checking;
  int unsigned run_from, req_from, halt_from, pend_at, chk_from;
  alu_rec_t    cur, pend;
  bit          pend_v;
  bit          exp_busy, exp_halted, exp_req;

  task automatic build(input logic [15:0] w, input logic [15:0] imm);
    pend.au   = w[15];
    pend.op   = w[14:11];
    pend.mode = w[10:9];
    pend.imm  = imm;
    pend.rn   = m_regs[w[5:3]];
    pend.rm   = m_regs[w[2:0]];
    pend.res  = alu_fn(pend);
    m_regs[w[8:6]] = pend.res;
    pend_v    = 1'b1;
  endtask

  // Memory responder + model + per-cycle compare, all on the falling edge.
  initial begin
    logic [15:0] w;
    instr_valid = 1'b0; instr_data = '0; Rd_data = '0;
    m_running = 0; m_halt = 0; m_in_imm = 0; checking = 0; pend_v = 0;
    cur = '0; pend = '0; m_pc = '0; m_word = '0; stall_addr = '0;
    run_from = 0; req_from = 0; halt_from = 0; pend_at = 0; chk_from = 0;
    forever begin
      @(negedge clk);
      if (pend_v && cyc >= pend_at) begin
        cur    = pend;
        pend_v = 1'b0;
      end
      exp_halted = m_halt && cyc >= halt_from;
      exp_busy   = m_running && cyc >= run_from && !exp_halted;
      exp_req    = exp_busy && cyc >= req_from;

      if (checking && cyc >= chk_from) begin
        chk("busy", busy, exp_busy);
        chk("halted", halted, exp_halted);
        chk("instr_req", instr_req, exp_req);
        if (exp_req) chk("instr_addr", instr_addr, m_pc);
        chk("useAU", useAU, cur.au);
        chk("OpcodeB", OpcodeB, cur.op);
        chk("Mode", Mode, cur.mode);
        chk("Immediate", Immediate, cur.imm);
        chk("Rn_data", Rn_data, cur.rn);
        chk("Rm_data", Rm_data, cur.rm);
      end

      instr_valid = 1'b0;
      if (exp_req) begin
        if (stall_left > 0 && m_pc == stall_addr) stall_left--;
        else instr_valid = 1'b1;
      end
      instr_data = mem[m_pc];
      Rd_data    = cur.res;

      if (instr_valid && rst_n) begin
        w    = mem[m_pc];
        m_pc = m_pc + 16'd1;
        if (m_in_imm) begin
          build(m_word, w);
          pend_at  = cyc + 2;
          req_from = cyc + 3;
          m_in_imm = 0;
        end else if (w == 16'hFFFF) begin
          m_halt    = 1;
          halt_from = cyc + 1;
        end else begin
          m_word = w;
          if (w[10:9] == 2'b01) begin
            m_in_imm = 1;
            req_from = cyc + 1;
          end else begin
            build(w, 16'h0000);
            pend_at  = cyc + 2;
            req_from = cyc + 3;
          end
        end
      end

      if (start && rst_n && !m_running && !m_halt) begin
        m_running = 1;
        run_from  = cyc + 1;
        req_from  = cyc + 1;
      end

      if (!rst_n) begin
        m_running = 0; m_halt = 0; m_in_imm = 0;
        m_pc = 16'h0000;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        pend     = '0;
        pend_v   = 1'b1;
        pend_at  = cyc + 1;
        checking = 1;
        chk_from = cyc + 1;
      end
    end
  end

  // Responder for the second DUT: zero-wait, tiny fixed program.
  initial begin
    instr_valid2 = 1'b1;
    Rd_data2     = 16'h1234;
    instr_data2  = 16'hFFFF;
    forever begin
      @(negedge clk);
      case (instr_addr2)
        16'hFFFF, 16'h0000: instr_data2 = 16'h0000;
        default:            instr_data2 = 16'hFFFF;
      endcase
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (halted !== 1'b1 && n < 200) begin tick(); n++; end
    chk(name, halted, 1'b1);
  endtask

  initial begin
    logic [15:0] addrs [$];
    int n;
    rst_n = 1'b0; start = 1'b0; rst2_n = 1'b0; start2 = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'hFFFF;

    // Test 1: immediate instruction then halt at address 2
    mem[0] = 16'h8A0B; mem[1] = 16'h0005; mem[2] = 16'hFFFF;
    tick(); tick(); tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_req", instr_req, 1'b0);
    chk("reset_Rn", Rn_data, 16'h0000);
    rst_n = 1'b1; tick();
    pulse_start();
    wait_halt("t1_halt");
    chk("t1_mode", Mode, 2'b01);
    chk("t1_imm", Immediate, 16'h0005);
    chk("t1_useAU", useAU, 1'b1);
    chk("t1_op", OpcodeB, 4'd1);
    for (int i = 0; i < 3; i++) begin pulse_start(); tick(); end
    chk("t1_still_halted", halted, 1'b1);
    chk("t1_not_busy", busy, 1'b0);
    chk("t1_no_req", instr_req, 1'b0);

    // Test 2: dependent chain with a 5-cycle fetch stall at address 5
    mem[0] = 16'h8A0B; mem[1] = 16'h0005;   // r0 = r1 + 5 = 5
    mem[2] = 16'h8A80; mem[3] = 16'h0003;   // r2 = r0 + 3 = 8
    mem[4] = 16'h08D0;                      // r3 = r2 ^ r0 = 13
    mem[5] = 16'h851A;                      // r4 = r3 - r2 = 5
    mem[6] = 16'h0163;                      // r5 = r4 | r3 = 13
    mem[7] = 16'hFFFF;
    stall_addr = 16'd5; stall_left = 5;
    do_reset();
    pulse_start();
    n = 0;
    while (!(instr_req === 1'b1 && instr_addr === 16'd5) && n < 100) begin tick(); n++; end
    chk("t2_reach_addr5", instr_addr, 16'd5);
    chk("t2_fwd_Rn", Rn_data, 16'd8);
    chk("t2_fwd_Rm", Rm_data, 16'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_stall_addr", instr_addr, 16'd5);
      chk("t2_stall_req", instr_req, 1'b1);
    end
    wait_halt("t2_halt");
    chk("t2_final_Rn", Rn_data, 16'd5);
    chk("t2_final_Rm", Rm_data, 16'd13);
    chk("t2_final_imm", Immediate, 16'h0000);
    chk("t2_final_mode", Mode, 2'b00);

    // Test 3: reset during EXEC aborts the write-back
    mem[0] = 16'h8A0B; mem[1] = 16'h0005;
    stall_left = 0;
    do_reset();
    pulse_start();
    n = 0;
    while (Immediate !== 16'h0005 && n < 40) begin tick(); n++; end
    chk("t3_reach_exec", Immediate, 16'h0005);
    rst_n = 1'b0; tick();
    chk("t3_req_after_rst", instr_req, 1'b0);
    chk("t3_busy_after_rst", busy, 1'b0);
    chk("t3_imm_after_rst", Immediate, 16'h0000);
    mem[0] = 16'h0000; mem[1] = 16'hFFFF;   // reads r0
    rst_n = 1'b1; tick();
    pulse_start();
    wait_halt("t3_halt");
    chk("t3_r0_unwritten", Rn_data, 16'h0000);

    // Test 4: RESET_PC = 16'hFFFF wraps to 0
    tick();
    rst2_n = 1'b1; tick();
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (instr_req2) addrs.push_back(instr_addr2);
      tick();
    end
    chk("t4_nfetch", addrs.size(), 3);
    chk("t4_addr0", (addrs.size() > 0) ? addrs[0] : 16'hDEAD, 16'hFFFF);
    chk("t4_addr1", (addrs.size() > 1) ? addrs[1] : 16'hDEAD, 16'h0000);
    chk("t4_addr2", (addrs.size() > 2) ? addrs[2] : 16'hDEAD, 16'h0001);
    chk("t4_halted", halted2, 1'b1);
    chk("t4_wb_visible", Rn_data2, 16'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
